// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the mem->wb pipeline register and its load aligner.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package mem_wb_stage_pkg;

    // Register file geometry
    localparam int RegAddrBus = 5;
    localparam int RegDataBus = 32;

    localparam logic [RegDataBus-1:0] ZeroWord = '0;

    // Load-type encodings carried down the pipe with each memory instruction
    localparam logic [2:0] LT_NONE = 3'd0;
    localparam logic [2:0] LT_LB   = 3'd1;
    localparam logic [2:0] LT_LBU  = 3'd2;
    localparam logic [2:0] LT_LH   = 3'd3;
    localparam logic [2:0] LT_LHU  = 3'd4;
    localparam logic [2:0] LT_LW   = 3'd5;
    localparam logic [2:0] LT_LWL  = 3'd6;
    localparam logic [2:0] LT_LWR  = 3'd7;

    // Bit positions inside the global 6-bit stall vector
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    // True when the load aligner's result (not the ALU result) is written back.
    function automatic logic lt_is_load(input logic [2:0] lt);
        case (lt)
            LT_LB, LT_LBU, LT_LH, LT_LHU, LT_LW, LT_LWL, LT_LWR: return 1'b1;
            default:                                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Load-data extraction: lane select, sign/zero extension, LWL/LWR merge, misalign detect.
// Latency: purely combinational.
// Backpressure: none; the enclosing stage decides when the result is captured.
//
// Ports:
//   ltype      load type (LT_*)
//   addr_lo    effective address bits [1:0]; selects the big-endian byte lane
//   rdata      word read from data RAM, lane 0 = [31:24]
//   rt_old     current rt value, supplies the bytes LWL/LWR do not overwrite
//   result     extracted/merged load value (ZeroWord for non-loads)
//   misaligned halfword on an odd address or word on a non-zero offset
module load_align
    import mem_wb_stage_pkg::*;
(
    input  logic [2:0]            ltype,
    input  logic [1:0]            addr_lo,
    input  logic [RegDataBus-1:0] rdata,
    input  logic [RegDataBus-1:0] rt_old,
    output logic [RegDataBus-1:0] result,
    output logic                  misaligned
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] lwl_word;
    logic [31:0] lwr_word;

    // Big-endian lane pick: lane 0 is the most significant byte.
    always_comb begin
        sel_byte = rdata[31:24];
        case (addr_lo)
            2'd0: sel_byte = rdata[31:24];
            2'd1: sel_byte = rdata[23:16];
            2'd2: sel_byte = rdata[15:8];
            2'd3: sel_byte = rdata[7:0];
            default: sel_byte = rdata[31:24];
        endcase
        // Only addr_lo[1] picks the half; addr_lo[0] is the misalign flag.
        sel_half = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    end

    // Unaligned word merges: LWL fills the high end of rt, LWR the low end.
    always_comb begin
        lwl_word = rdata;
        lwr_word = rdata;
        case (addr_lo)
            2'd0: begin
                lwl_word = rdata;
                lwr_word = {rt_old[31:8], rdata[31:24]};
            end
            2'd1: begin
                lwl_word = {rdata[23:0], rt_old[7:0]};
                lwr_word = {rt_old[31:16], rdata[31:16]};
            end
            2'd2: begin
                lwl_word = {rdata[15:0], rt_old[15:0]};
                lwr_word = {rt_old[31:24], rdata[31:8]};
            end
            2'd3: begin
                lwl_word = {rdata[7:0], rt_old[23:0]};
                lwr_word = rdata;
            end
            default: begin
                lwl_word = rdata;
                lwr_word = rdata;
            end
        endcase
    end

    always_comb begin
        result     = ZeroWord;
        misaligned = 1'b0;
        case (ltype)
            LT_LB:  result = {{24{sel_byte[7]}}, sel_byte};
            LT_LBU: result = {24'h0, sel_byte};
            LT_LH: begin
                result     = {{16{sel_half[15]}}, sel_half};
                misaligned = addr_lo[0];
            end
            LT_LHU: begin
                result     = {16'h0, sel_half};
                misaligned = addr_lo[0];
            end
            LT_LW: begin
                result     = rdata;
                misaligned = |addr_lo;
            end
            LT_LWL: result = lwl_word;
            LT_LWR: result = lwr_word;
            default: begin
                result     = ZeroWord;
                misaligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Mem->wb pipeline register producing the regfile write triple (we/waddr/wdata).
// Latency: one clk from mem-stage inputs to wb_* outputs.
// Backpressure: global stall vector; mem stalled alone inserts a bubble, wb stalled holds.
//
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   stall[5:0]     global stall vector (bit STALL_MEM, bit STALL_WB used here)
//   flush          kills the entry being captured (exception/eret)
//   mem_*          instruction leaving the memory stage
//   wb_wreg/wd/wdata  registered regfile write port
//   wb_align_err   one-cycle pulse when a misaligned load was squashed
//   wb_valid       stage holds a real (non-bubble) instruction
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = RegDataBus,
    parameter int ADDR_W = RegAddrBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic              mem_wreg,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [2:0]        mem_ltype,
    input  logic [1:0]        mem_addr_lo,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] mem_rt_old,
    output logic              wb_wreg,
    output logic [ADDR_W-1:0] wb_wd,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              wb_align_err,
    output logic              wb_valid
);

    logic [DATA_W-1:0] load_result;
    logic              load_misaligned;
    logic [DATA_W-1:0] next_wdata;
    logic              mem_stalled;
    logic              wb_stalled;

    // The lower stall bits belong to earlier stages.
    logic unused_stall;
    assign unused_stall = ^stall[3:0];

    assign mem_stalled = stall[STALL_MEM];
    assign wb_stalled  = stall[STALL_WB];

    load_align u_load_align (
        .ltype      (mem_ltype),
        .addr_lo    (mem_addr_lo),
        .rdata      (mem_rdata),
        .rt_old     (mem_rt_old),
        .result     (load_result),
        .misaligned (load_misaligned)
    );

    assign next_wdata = lt_is_load(mem_ltype) ? load_result : mem_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_wreg      <= 1'b0;
            wb_wd        <= '0;
            wb_wdata     <= '0;
            wb_align_err <= 1'b0;
            wb_valid     <= 1'b0;
        end else if (flush || (mem_stalled && !wb_stalled)) begin
            // Flush always wins, even over a wb stall; a stalled mem stage
            // with a free wb stage sends a bubble down.
            wb_wreg      <= 1'b0;
            wb_wd        <= '0;
            wb_wdata     <= '0;
            wb_align_err <= 1'b0;
            wb_valid     <= 1'b0;
        end else if (!mem_stalled) begin
            wb_valid <= 1'b1;
            wb_wd    <= mem_wd;
            if (load_misaligned) begin
                // Keep the destination for the exception path, drop the write.
                wb_wreg      <= 1'b0;
                wb_wdata     <= '0;
                wb_align_err <= 1'b1;
            end else begin
                wb_wreg      <= mem_wreg;
                wb_wdata     <= next_wdata;
                wb_align_err <= 1'b0;
            end
        end else begin
            // wb stalled: hold the write triple; the alignment error must
            // not be reported twice for the same instruction.
            wb_align_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        mem_wreg;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_ltype;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_rdata;
    logic [31:0] mem_rt_old;
    logic        wb_wreg;
    logic [4:0]  wb_wd;
    logic [31:0] wb_wdata;
    logic        wb_align_err;
    logic        wb_valid;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        wreg;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic        aerr;
        logic        vld;
    } st_t;

    st_t exp_st;

    mem_wb_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .mem_wreg     (mem_wreg),
        .mem_wd       (mem_wd),
        .mem_wdata    (mem_wdata),
        .mem_ltype    (mem_ltype),
        .mem_addr_lo  (mem_addr_lo),
        .mem_rdata    (mem_rdata),
        .mem_rt_old   (mem_rt_old),
        .wb_wreg      (wb_wreg),
        .wb_wd        (wb_wd),
        .wb_wdata     (wb_wdata),
        .wb_align_err (wb_align_err),
        .wb_valid     (wb_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference extraction written as shifts/masks over the big-endian word.
    function automatic logic [31:0] ref_load(input logic [2:0] lt, input int k,
                                             input logic [31:0] rd, input logic [31:0] rt,
                                             input logic [31:0] alu, output logic mis);
        logic [63:0] rd64, rt64, lo_mask;
        logic [7:0]  b;
        logic [15:0] h;
        rd64 = {32'h0, rd};
        rt64 = {32'h0, rt};
        b = 8'((rd >> (8 * (3 - k))) & 32'hFF);
        h = 16'((rd >> ((k >= 2) ? 0 : 16)) & 32'hFFFF);
        mis = 1'b0;
        case (lt)
            LT_LB:  return {{24{b[7]}}, b};
            LT_LBU: return {24'h0, b};
            LT_LH:  begin mis = (k % 2) != 0; return mis ? 32'h0 : {{16{h[15]}}, h}; end
            LT_LHU: begin mis = (k % 2) != 0; return mis ? 32'h0 : {16'h0, h}; end
            LT_LW:  begin mis = k != 0;       return mis ? 32'h0 : rd; end
            LT_LWL: begin
                lo_mask = (64'd1 << (8 * k)) - 64'd1;
                return 32'(((rd64 << (8 * k)) & 64'hFFFF_FFFF) | (rt64 & lo_mask));
            end
            LT_LWR: begin
                lo_mask = (64'd1 << (8 * (k + 1))) - 64'd1;
                return 32'((rd64 >> (8 * (3 - k))) | (rt64 & ~lo_mask & 64'hFFFF_FFFF));
            end
            default: return alu;
        endcase
    endfunction

    function automatic st_t model_next(input st_t cur);
        st_t n;
        logic mis;
        logic [31:0] v;
        n = '{1'b0, 5'd0, 32'd0, 1'b0, 1'b0};
        if (flush) return n;
        if (stall[4] && !stall[5]) return n;
        if (!stall[4]) begin
            v = ref_load(mem_ltype, int'(mem_addr_lo), mem_rdata, mem_rt_old, mem_wdata, mis);
            n.vld = 1'b1;
            n.wd = mem_wd;
            n.aerr = mis;
            n.wreg = mis ? 1'b0 : mem_wreg;
            n.wdata = v;
            return n;
        end
        n = cur;
        n.aerr = 1'b0;
        return n;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".wreg"},  32'(wb_wreg),      32'(exp_st.wreg));
        chk({tag, ".wd"},    32'(wb_wd),        32'(exp_st.wd));
        chk({tag, ".wdata"}, wb_wdata,          exp_st.wdata);
        chk({tag, ".aerr"},  32'(wb_align_err), 32'(exp_st.aerr));
        chk({tag, ".vld"},   32'(wb_valid),     32'(exp_st.vld));
    endtask

    task automatic tick(input string tag);
        st_t nxt;
        nxt = model_next(exp_st);
        @(posedge clk);
        #1;
        exp_st = nxt;
        check_all(tag);
    endtask

    task automatic drive(input logic [2:0] lt, input logic [1:0] a, input logic [31:0] rd,
                         input logic [31:0] rt, input logic [31:0] alu, input logic [4:0] wd);
        mem_ltype = lt; mem_addr_lo = a; mem_rdata = rd; mem_rt_old = rt;
        mem_wdata = alu; mem_wd = wd; mem_wreg = 1'b1;
    endtask

    initial begin
        rst = 1'b1; stall = 6'b0; flush = 1'b0;
        drive(LT_NONE, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0);
        mem_wreg = 1'b0;
        exp_st = '{1'b0, 5'd0, 32'd0, 1'b0, 1'b0};
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Byte lanes
        drive(LT_LB, 2'd0, 32'h807F01FF, 32'h0, 32'h0, 5'd2);
        tick("lb0");  chk("lb0.const", wb_wdata, 32'hFFFFFF80);
        drive(LT_LBU, 2'd0, 32'h807F01FF, 32'h0, 32'h0, 5'd2);
        tick("lbu0"); chk("lbu0.const", wb_wdata, 32'h00000080);
        drive(LT_LB, 2'd3, 32'h807F01FF, 32'h0, 32'h0, 5'd2);
        tick("lb3");  chk("lb3.const", wb_wdata, 32'hFFFFFFFF); chk("lb3.we", 32'(wb_wreg), 32'd1);

        // Halfwords and misalignment
        drive(LT_LH, 2'd2, 32'h12348001, 32'h0, 32'h0, 5'd4);
        tick("lh2");  chk("lh2.const", wb_wdata, 32'hFFFF8001);
        drive(LT_LHU, 2'd2, 32'h12348001, 32'h0, 32'h0, 5'd4);
        tick("lhu2"); chk("lhu2.const", wb_wdata, 32'h00008001);
        drive(LT_LH, 2'd1, 32'h12348001, 32'h0, 32'h0, 5'd9);
        tick("lh1");  chk("lh1.aerr", 32'(wb_align_err), 32'd1); chk("lh1.wd", 32'(wb_wd), 32'd9);
        drive(LT_NONE, 2'd0, 32'h0, 32'h0, 32'h77, 5'd10);
        tick("after_mis"); chk("after_mis.aerr", 32'(wb_align_err), 32'd0);

        // Misaligned word captured, then held under wb stall: pulse must not repeat
        drive(LT_LW, 2'd2, 32'hCAFEF00D, 32'h0, 32'h0, 5'd11);
        tick("lw2");
        stall = 6'b111111;
        tick("lw2_hold"); chk("lw2_hold.aerr", 32'(wb_align_err), 32'd0);
        stall = 6'b0;

        // LWL/LWR merges
        drive(LT_LWL, 2'd2, 32'hAABBCCDD, 32'h11223344, 32'h0, 5'd5);
        tick("lwl2"); chk("lwl2.const", wb_wdata, 32'hCCDD3344);
        drive(LT_LWR, 2'd1, 32'hAABBCCDD, 32'h11223344, 32'h0, 5'd5);
        tick("lwr1"); chk("lwr1.const", wb_wdata, 32'h1122AABB);
        drive(LT_LWR, 2'd3, 32'hAABBCCDD, 32'h11223344, 32'h0, 5'd5);
        tick("lwr3"); chk("lwr3.const", wb_wdata, 32'hAABBCCDD);

        // Stall protocol with ALU result 0x5 pending to $3
        drive(LT_NONE, 2'd0, 32'h0, 32'h0, 32'h5, 5'd3);
        stall = 6'b011111;
        tick("st_bubble"); chk("st_bubble.we", 32'(wb_wreg), 32'd0);
        stall = 6'b111111;
        for (int i = 0; i < 3; i++) tick("st_frozen");
        stall = 6'b000000;
        tick("st_release"); chk("st_release.wd", 32'(wb_wd), 32'd3); chk("st_release.wdata", wb_wdata, 32'h5);

        // Bypass window: $7=0xDEAD visible for exactly one cycle
        drive(LT_NONE, 2'd0, 32'h0, 32'h0, 32'hDEAD, 5'd7);
        tick("byp"); chk("byp.wdata", wb_wdata, 32'hDEAD);
        drive(LT_NONE, 2'd0, 32'h0, 32'h0, 32'h1, 5'd8);
        tick("byp_next"); chk("byp_next.wd", 32'(wb_wd), 32'd8);

        // Flush beats a wb stall
        drive(LT_NONE, 2'd0, 32'h0, 32'h0, 32'h1234, 5'd12);
        stall = 6'b111111; flush = 1'b1;
        tick("flush"); chk("flush.wdata", wb_wdata, 32'h0); chk("flush.vld", 32'(wb_valid), 32'd0);
        flush = 1'b0; stall = 6'b0;

        // Asynchronous reset between edges, then release under stall
        drive(LT_NONE, 2'd0, 32'h0, 32'h0, 32'hBEEF, 5'd13);
        tick("pre_rst");
        #2 rst = 1'b1;
        #1;
        exp_st = '{1'b0, 5'd0, 32'd0, 1'b0, 1'b0};
        check_all("async_rst");
        stall = 6'b111111;
        #2 rst = 1'b0;
        tick("rst_release_stall");
        stall = 6'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            mem_ltype   = 3'($urandom_range(0, 7));
            mem_addr_lo = 2'($urandom_range(0, 3));
            mem_rdata   = $urandom;
            mem_rt_old  = $urandom;
            mem_wdata   = $urandom;
            mem_wd      = 5'($urandom_range(0, 31));
            mem_wreg    = 1'($urandom_range(0, 1));
            stall       = ($urandom_range(0, 9) < 6) ? 6'b0 : 6'($urandom);
            flush       = ($urandom_range(0, 19) == 0);
            tick("rand");
        end
        flush = 1'b0; stall = 6'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
